// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants for the two-port memory arbiter: FSM state
//               encodings, requester port identifiers and arbitration modes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_arb_pkg;

   // FSM state encodings
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_RD_WAIT = 1'b1;

   // Requester port identifiers
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_AUX  = 1'b1;

   // Arbitration modes
   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
//==============================================================================
// Module      : rr_pick2
// Description : Combinational two-way request picker. Supports round-robin
//               (alternate on contention) and fixed priority (port 0 wins).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       prio_mode,
   output logic       winner,
   output logic       any_req
);

   // Select the winning port; with no request the result is don't-care (core)
   always_comb begin
      any_req = req[0] | req[1];
      if (req[0] && req[1]) begin
         winner = prio_mode ? PORT_CORE : ~last_grant;
      end else if (req[1]) begin
         winner = PORT_AUX;
      end else begin
         winner = PORT_CORE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter in front of a single-port word memory.
//               Issues one memory transaction per grant and returns read data
//               with a one-cycle valid pulse. One read outstanding at a time.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 1,
   parameter int PRIO_MODE = 0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_out,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_data_in
);

   // Wait-counter load value; only meaningful when READ_LAT > 0
   localparam int         LAT_M1   = (READ_LAT > 0) ? READ_LAT - 1 : 0;
   localparam logic [1:0] LAT_INIT = LAT_M1[1:0];

   logic [0:0]        state;
   logic              owner;
   logic              last_grant;
   logic [1:0]        lat_cnt;
   logic [ADDR_W-1:0] rd_addr;

   logic              winner;
   logic              any_req;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              issue;
   logic              rd_done;
   logic              ret_valid;
   logic              ret_port;

   rr_pick2 u_pick (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .prio_mode  (PRIO_MODE == PRIO_FIXED),
      .winner     (winner),
      .any_req    (any_req)
   );

   // Winner request mux and cycle qualifiers; reset masks everything so the
   // outputs show reset values while reset is held
   always_comb begin
      win_we    = (winner == PORT_AUX) ? m1_we    : m0_we;
      win_addr  = (winner == PORT_AUX) ? m1_addr  : m0_addr;
      win_wdata = (winner == PORT_AUX) ? m1_wdata : m0_wdata;
      issue     = !reset && (state == ST_IDLE) && any_req;
      rd_done   = !reset && (state == ST_RD_WAIT) && (lat_cnt == 2'd0);
      ret_valid = 1'b0;
      ret_port  = owner;
      if (issue && !win_we && (READ_LAT == 0)) begin
         // zero-latency memory: data comes back in the issue cycle
         ret_valid = 1'b1;
         ret_port  = winner;
      end else if (rd_done) begin
         ret_valid = 1'b1;
         ret_port  = owner;
      end
   end

   // Memory bus, grant and read-return outputs
   always_comb begin
      mem_address  = '0;
      mem_data_out = '0;
      mem_we       = 1'b0;
      m0_gnt       = 1'b0;
      m1_gnt       = 1'b0;
      m0_rvalid    = 1'b0;
      m1_rvalid    = 1'b0;
      m0_rdata     = '0;
      m1_rdata     = '0;
      if (issue) begin
         mem_address  = win_addr;
         mem_we       = win_we;
         mem_data_out = win_we ? win_wdata : '0;
         if (winner == PORT_AUX) begin
            m1_gnt = 1'b1;
         end else begin
            m0_gnt = 1'b1;
         end
      end else if (!reset && (state == ST_RD_WAIT)) begin
         mem_address = rd_addr;
      end
      if (ret_valid) begin
         if (ret_port == PORT_AUX) begin
            m1_rvalid = 1'b1;
            m1_rdata  = mem_data_in;
         end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = mem_data_in;
         end
      end
   end

   // Arbitration state, ownership tracking and read-latency countdown
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         owner      <= PORT_CORE;
         last_grant <= PORT_AUX;
         lat_cnt    <= 2'd0;
         rd_addr    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  last_grant <= winner;
                  owner      <= winner;
                  if (!win_we && (READ_LAT != 0)) begin
                     state   <= ST_RD_WAIT;
                     lat_cnt <= LAT_INIT;
                     rd_addr <= win_addr;
                  end
               end
            end
            ST_RD_WAIT: begin
               if (lat_cnt == 2'd0) begin
                  state <= ST_IDLE;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Four instances cover
//               round-robin/fixed priority and read latencies 0, 1 and 3.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int NI = 4;   // 0: RR lat1, 1: fixed lat1, 2: RR lat0, 3: RR lat3
   localparam int NV = 12;

   logic        clk;
   logic        reset;
   logic        m0_req [NI];
   logic        m0_we [NI];
   logic [31:0] m0_addr [NI];
   logic [31:0] m0_wdata [NI];
   logic        m0_gnt [NI];
   logic        m0_rvalid [NI];
   logic [31:0] m0_rdata [NI];
   logic        m1_req [NI];
   logic        m1_we [NI];
   logic [31:0] m1_addr [NI];
   logic [31:0] m1_wdata [NI];
   logic        m1_gnt [NI];
   logic        m1_rvalid [NI];
   logic [31:0] m1_rdata [NI];
   logic [31:0] mem_address [NI];
   logic [31:0] mem_data_out [NI];
   logic        mem_we [NI];
   logic [31:0] mem_data_in [NI];

   logic [31:0] mem [NI][1024];
   logic [31:0] rd_q [NI];
   logic        pl_we;
   logic [1:0]  pl_k;
   logic [9:0]  pl_idx;
   logic [31:0] pl_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          inst;
      logic        r0, w0;
      logic [31:0] a0, d0;
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic        g0, g1, mwe;
      logic [31:0] maddr, mdout;
   } vec_t;

   vec_t vecs [NV];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .PRIO_MODE(0)) u_rr_l1 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
      .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
      .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
      .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
      .mem_address(mem_address[0]), .mem_data_out(mem_data_out[0]),
      .mem_we(mem_we[0]), .mem_data_in(mem_data_in[0]));

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .PRIO_MODE(1)) u_fx_l1 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
      .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
      .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
      .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
      .mem_address(mem_address[1]), .mem_data_out(mem_data_out[1]),
      .mem_we(mem_we[1]), .mem_data_in(mem_data_in[1]));

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(0), .PRIO_MODE(0)) u_rr_l0 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req[2]), .m0_we(m0_we[2]), .m0_addr(m0_addr[2]), .m0_wdata(m0_wdata[2]),
      .m0_gnt(m0_gnt[2]), .m0_rvalid(m0_rvalid[2]), .m0_rdata(m0_rdata[2]),
      .m1_req(m1_req[2]), .m1_we(m1_we[2]), .m1_addr(m1_addr[2]), .m1_wdata(m1_wdata[2]),
      .m1_gnt(m1_gnt[2]), .m1_rvalid(m1_rvalid[2]), .m1_rdata(m1_rdata[2]),
      .mem_address(mem_address[2]), .mem_data_out(mem_data_out[2]),
      .mem_we(mem_we[2]), .mem_data_in(mem_data_in[2]));

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .PRIO_MODE(0)) u_rr_l3 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req[3]), .m0_we(m0_we[3]), .m0_addr(m0_addr[3]), .m0_wdata(m0_wdata[3]),
      .m0_gnt(m0_gnt[3]), .m0_rvalid(m0_rvalid[3]), .m0_rdata(m0_rdata[3]),
      .m1_req(m1_req[3]), .m1_we(m1_we[3]), .m1_addr(m1_addr[3]), .m1_wdata(m1_wdata[3]),
      .m1_gnt(m1_gnt[3]), .m1_rvalid(m1_rvalid[3]), .m1_rdata(m1_rdata[3]),
      .mem_address(mem_address[3]), .mem_data_out(mem_data_out[3]),
      .mem_we(mem_we[3]), .mem_data_in(mem_data_in[3]));

   // Memory models: registered read for latency >= 1 (address is held by the
   // arbiter), combinational read for the zero-latency instance
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (mem_we[k]) mem[k][mem_address[k][11:2]] <= mem_data_out[k];
         rd_q[k] <= mem[k][mem_address[k][11:2]];
      end
      if (pl_we) mem[pl_k][pl_idx] <= pl_data;
   end

   assign mem_data_in[0] = rd_q[0];
   assign mem_data_in[1] = rd_q[1];
   assign mem_data_in[2] = mem[2][mem_address[2][11:2]];
   assign mem_data_in[3] = rd_q[3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
      m0_req[k] = r0; m0_we[k] = w0; m0_addr[k] = a0; m0_wdata[k] = d0;
      m1_req[k] = r1; m1_we[k] = w1; m1_addr[k] = a1; m1_wdata[k] = d1;
   endtask

   task automatic clear_inputs;
      for (int k = 0; k < NI; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic preload(input logic [1:0] k, input logic [9:0] idx, input logic [31:0] d);
      pl_k = k; pl_idx = idx; pl_data = d; pl_we = 1'b1;
      tick();
      pl_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      int c0, c1;
      logic [31:0] g;
      reset = 1'b1;
      pl_we = 1'b0; pl_k = 2'd0; pl_idx = 10'd0; pl_data = 32'h0;
      clear_inputs();

      // {inst, m0 req/we/addr/wdata, m1 req/we/addr/wdata, gnt0, gnt1, mem_we, mem_address, mem_data_out}
      vecs[0]  = '{0, 1'b0,1'b0,32'h0,32'h0,          1'b0,1'b0,32'h0,32'h0,          1'b0,1'b0,1'b0,32'h0,32'h0};
      vecs[1]  = '{0, 1'b1,1'b1,32'h100,32'hA,        1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,1'b1,32'h100,32'hA};
      vecs[2]  = '{0, 1'b1,1'b1,32'h104,32'hB,        1'b1,1'b1,32'h200,32'hC,        1'b0,1'b1,1'b1,32'h200,32'hC};
      vecs[3]  = '{0, 1'b1,1'b1,32'h104,32'hB,        1'b1,1'b1,32'h200,32'hC,        1'b1,1'b0,1'b1,32'h104,32'hB};
      vecs[4]  = '{0, 1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,32'h800,32'h12345678, 1'b0,1'b1,1'b1,32'h800,32'h12345678};
      vecs[5]  = '{0, 1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,32'h204,32'hD,        1'b0,1'b1,1'b1,32'h204,32'hD};
      vecs[6]  = '{0, 1'b1,1'b1,32'h108,32'hE,        1'b1,1'b1,32'h208,32'hF,        1'b1,1'b0,1'b1,32'h108,32'hE};
      vecs[7]  = '{0, 1'b1,1'b0,32'h10,32'h55,        1'b0,1'b0,32'h0,32'h0,          1'b1,1'b0,1'b0,32'h10,32'h0};
      vecs[8]  = '{1, 1'b1,1'b1,32'h300,32'h1,        1'b1,1'b1,32'h400,32'h2,        1'b1,1'b0,1'b1,32'h300,32'h1};
      vecs[9]  = '{1, 1'b1,1'b1,32'h300,32'h1,        1'b1,1'b1,32'h400,32'h2,        1'b1,1'b0,1'b1,32'h300,32'h1};
      vecs[10] = '{1, 1'b0,1'b0,32'h0,32'h0,          1'b1,1'b1,32'h400,32'h2,        1'b0,1'b1,1'b1,32'h400,32'h2};
      vecs[11] = '{1, 1'b1,1'b1,32'h300,32'h1,        1'b1,1'b1,32'h400,32'h2,        1'b1,1'b0,1'b1,32'h300,32'h1};

      tick();

      // Reset held with both requests active: no activity, then port 0 first
      for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b1, 32'h44, 32'h2);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk1($sformatf("rst%0d_gnt0", c), m0_gnt[0], 1'b0);
         chk1($sformatf("rst%0d_gnt1", c), m1_gnt[0], 1'b0);
         chk1($sformatf("rst%0d_rvalid", c), m0_rvalid[0] | m1_rvalid[0], 1'b0);
         chk1($sformatf("rst%0d_mem_we", c), mem_we[0], 1'b0);
         chk($sformatf("rst%0d_mem_address", c), mem_address[0], 32'h0);
         tick();
      end
      reset = 1'b0;
      @(negedge clk);
      chk1("first_gnt0_rr", m0_gnt[0], 1'b1);
      chk1("first_gnt1_rr", m1_gnt[0], 1'b0);
      chk1("first_gnt0_fx", m0_gnt[1], 1'b1);
      tick();

      // Table-driven single-cycle vectors
      prev = -1;
      for (int i = 0; i < NV; i++) begin
         int k;
         k = vecs[i].inst;
         if (k != prev) begin
            do_reset();
            prev = k;
         end
         drive(k, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
               vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
         @(negedge clk);
         chk1($sformatf("v%0d_gnt0", i), m0_gnt[k], vecs[i].g0);
         chk1($sformatf("v%0d_gnt1", i), m1_gnt[k], vecs[i].g1);
         chk1($sformatf("v%0d_mem_we", i), mem_we[k], vecs[i].mwe);
         chk($sformatf("v%0d_mem_address", i), mem_address[k], vecs[i].maddr);
         chk($sformatf("v%0d_mem_data_out", i), mem_data_out[k], vecs[i].mdout);
         chk1($sformatf("v%0d_rvalid", i), m0_rvalid[k] | m1_rvalid[k], 1'b0);
         tick();
      end

      // Single read with latency 1
      do_reset();
      preload(2'd0, 10'h004, 32'hDEADBEEF);
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk1("rd1_gnt", m0_gnt[0], 1'b1);
      chk("rd1_addr", mem_address[0], 32'h10);
      chk1("rd1_we", mem_we[0], 1'b0);
      chk1("rd1_rvalid_n", m0_rvalid[0], 1'b0);
      tick();
      clear_inputs();
      @(negedge clk);
      chk1("rd1_rvalid", m0_rvalid[0], 1'b1);
      chk("rd1_rdata", m0_rdata[0], 32'hDEADBEEF);
      chk("rd1_hold_addr", mem_address[0], 32'h10);
      chk1("rd1_m1_rvalid", m1_rvalid[0], 1'b0);
      chk("rd1_m1_rdata", m1_rdata[0], 32'h0);
      chk1("rd1_m1_gnt", m1_gnt[0], 1'b0);
      tick();

      // Write passthrough from port 1, readback from port 0
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h800, 32'h12345678);
      @(negedge clk);
      chk1("wr_gnt1", m1_gnt[0], 1'b1);
      chk1("wr_we", mem_we[0], 1'b1);
      chk("wr_addr", mem_address[0], 32'h800);
      chk("wr_data", mem_data_out[0], 32'h12345678);
      tick();
      drive(0, 1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk1("wr_rb_gnt", m0_gnt[0], 1'b1);
      chk1("wr_rb_we", mem_we[0], 1'b0);
      tick();
      clear_inputs();
      @(negedge clk);
      chk1("wr_rb_rvalid", m0_rvalid[0], 1'b1);
      chk("wr_rb_rdata", m0_rdata[0], 32'h12345678);
      tick();

      // Continuous contention, 4 writes per port, round-robin and fixed
      for (int k = 0; k < 2; k++) begin
         do_reset();
         c0 = 0;
         c1 = 0;
         for (int cyc = 0; cyc < 8; cyc++) begin
            drive(k, c0 < 4, 1'b1, 32'h100 + 32'(4 * c0), 32'(c0),
                     c1 < 4, 1'b1, 32'h200 + 32'(4 * c1), 32'(c1));
            @(negedge clk);
            g = m1_gnt[k] ? 32'd1 : (m0_gnt[k] ? 32'd0 : 32'd2);
            if (k == 0) chk($sformatf("rr_order_c%0d", cyc), g, 32'(cyc % 2));
            else        chk($sformatf("fx_order_c%0d", cyc), g, (cyc < 4) ? 32'd0 : 32'd1);
            chk1($sformatf("both_gnt_k%0d_c%0d", k, cyc), m0_gnt[k] & m1_gnt[k], 1'b0);
            if (m0_gnt[k]) c0++;
            if (m1_gnt[k]) c1++;
            tick();
         end
      end

      // Read latency 0: data returns in the issue cycle
      do_reset();
      preload(2'd2, 10'h008, 32'hCAFEF00D);
      drive(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk1("l0_gnt0", m0_gnt[2], 1'b1);
      chk1("l0_rvalid0", m0_rvalid[2], 1'b1);
      chk("l0_rdata0", m0_rdata[2], 32'hCAFEF00D);
      chk1("l0_m1_rvalid", m1_rvalid[2], 1'b0);
      tick();
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      @(negedge clk);
      chk1("l0_gnt1", m1_gnt[2], 1'b1);
      chk1("l0_rvalid1", m1_rvalid[2], 1'b1);
      chk("l0_rdata1", m1_rdata[2], 32'hCAFEF00D);
      chk1("l0_m0_rvalid", m0_rvalid[2], 1'b0);
      chk("l0_m0_rdata", m0_rdata[2], 32'h0);
      tick();

      // Read latency 3 with a port-1 request raised at N+1
      do_reset();
      preload(2'd3, 10'h008, 32'hCAFEF00D);
      drive(3, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk1("l3_gnt0_n", m0_gnt[3], 1'b1);
      tick();
      drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      for (int c = 1; c < 3; c++) begin
         @(negedge clk);
         chk1($sformatf("l3_gnt1_n%0d", c), m1_gnt[3], 1'b0);
         chk1($sformatf("l3_rvalid_n%0d", c), m0_rvalid[3], 1'b0);
         chk($sformatf("l3_addr_n%0d", c), mem_address[3], 32'h20);
         tick();
      end
      @(negedge clk);
      chk1("l3_rvalid_n3", m0_rvalid[3], 1'b1);
      chk("l3_rdata_n3", m0_rdata[3], 32'hCAFEF00D);
      chk1("l3_gnt1_n3", m1_gnt[3], 1'b0);
      chk1("l3_m1_rvalid_n3", m1_rvalid[3], 1'b0);
      tick();
      @(negedge clk);
      chk1("l3_gnt1_n4", m1_gnt[3], 1'b1);
      tick();
      clear_inputs();
      tick();
      tick();
      @(negedge clk);
      chk1("l3_m1_rvalid_n7", m1_rvalid[3], 1'b1);
      chk("l3_m1_rdata_n7", m1_rdata[3], 32'hCAFEF00D);
      chk1("l3_m0_rvalid_n7", m0_rvalid[3], 1'b0);
      tick();

      // Reset mid-read with latency 3
      drive(3, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk1("rmr_gnt", m0_gnt[3], 1'b1);
      tick();
      clear_inputs();
      reset = 1'b1;
      @(negedge clk);
      chk1("rmr_rvalid_n1", m0_rvalid[3], 1'b0);
      chk("rmr_addr_n1", mem_address[3], 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk1("rmr_rvalid_n2", m0_rvalid[3], 1'b0);
      chk("rmr_idle_addr_n2", mem_address[3], 32'h0);
      tick();
      @(negedge clk);
      chk1("rmr_rvalid_n3", m0_rvalid[3], 1'b0);
      tick();
      drive(3, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk1("rmr_new_gnt", m0_gnt[3], 1'b1);
      tick();
      clear_inputs();
      tick();
      tick();
      @(negedge clk);
      chk1("rmr_new_rvalid", m0_rvalid[3], 1'b1);
      chk("rmr_new_rdata", m0_rdata[3], 32'hCAFEF00D);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port word memory (address, data_in, data_out, we).
- Port 0 is the core. Port 1 is a secondary master, such as a program loader or DMA.
- Serialises accesses, issues one memory transaction per grant, and returns read data with a valid pulse.
- Only one read is outstanding at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- READ_LAT, 1, cycles from address presented to memory data_out valid; legal range 0..3
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 always wins)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 request; held with m0_we/m0_addr/m0_wdata stable until m0_gnt
- m0_we  in  1  port 0 write enable (1 = write, 0 = read)
- m0_addr  in  ADDR_W  port 0 byte address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  one-cycle pulse: port 0 request is on the memory bus this cycle
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  DATA_W  read data to port 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_address  out  ADDR_W  to memory address
- mem_data_out  out  DATA_W  to memory data_in
- mem_we  out  1  to memory we
- mem_data_in  in  DATA_W  from memory data_out

Behaviour:
- States: IDLE, RD_WAIT.
- Registers: state, owner (1 bit), last_grant (1 bit), lat_cnt (2 bits), latched address.
- Reset values:
  - state = IDLE, last_grant = 1, lat_cnt = 0
  - all gnt/rvalid = 0, mem_we = 0, mem_address = 0, mem_data_out = 0
  - m0_rdata and m1_rdata = 0 whenever their rvalid is 0
- IDLE with no req: mem_address = 0, mem_we = 0, mem_data_out = 0.
- IDLE with any req, winner chosen combinationally:
  - PRIO_MODE = 1: port 0 if m0_req.
  - PRIO_MODE = 0, single req: that port wins.
  - PRIO_MODE = 0, both req: the port != last_grant wins.
- Issue cycle N:
  - mem_address = winner addr, mem_we = winner we, mem_data_out = winner wdata (0 on a read).
  - winner gnt = 1; last_grant <= winner; owner <= winner.
- Write: complete at N. State stays IDLE, so back-to-back writes issue every cycle.
- Read, READ_LAT = 0: owner rvalid = 1 and rdata = mem_data_in in cycle N. Stay IDLE.
- Read, READ_LAT > 0: go to RD_WAIT with lat_cnt = READ_LAT-1.
- RD_WAIT:
  - mem_address held at the latched read address; mem_we = 0; no gnt.
  - Decrement lat_cnt each cycle.
  - When lat_cnt == 0: owner rvalid = 1, owner rdata = mem_data_in (combinational pass), next state IDLE.
  - Result: rvalid at cycle N+READ_LAT; next issue no earlier than N+READ_LAT+1.
- Requests arriving during RD_WAIT wait; arbitration happens on the IDLE cycle.
- Never assert both gnt lines in the same cycle. Never assert rvalid to the non-owner.
- Reset asserted mid-read: the read is abandoned, no rvalid is produced, and all outputs take reset values next cycle.
- A requester that drops req before gnt: not a legal protocol event. The arbiter simply skips that port.
- Address is passed unmodified; no alignment or range checks. The address[11] MMIO region is treated like any other address.
- Round-robin fairness: with both ports requesting continuously, grants alternate strictly 0,1,0,1…

Decomposition:
- Shared package mem_arb_pkg:
  - state encodings ST_IDLE and ST_RD_WAIT
  - port constants PORT_CORE = 0 and PORT_AUX = 1
  - PRIO_RR = 0 and PRIO_FIXED = 1
- One sub-module, rr_pick2: purely combinational 2-way picker.
  - Inputs: req[1:0], last_grant, prio_mode.
  - Outputs: winner, any_req.
- FSM and muxing stay in mem_arbiter.

Test Plan:
- Reset: hold reset 3 cycles with both reqs = 1 -> all gnt/rvalid/mem_we = 0, mem_address = 0. The first grant after release goes to port 0.
- Single read, READ_LAT = 1: memory[0x10] = 0xDEADBEEF; m0 reads 0x10 -> m0_gnt at N with mem_address = 0x10, mem_we = 0; m0_rvalid at N+1 with m0_rdata = 0xDEADBEEF; m1 signals stay 0.
- Write passthrough: m1 writes 0x12345678 to 0x800 -> one cycle with mem_we = 1, mem_address = 0x800, mem_data_out = 0x12345678, m1_gnt = 1; readback by m0 returns 0x12345678.
- Contention, PRIO_MODE = 0: both ports issue 4 writes continuously -> grant order 0,1,0,1,0,1,0,1 over 8 consecutive cycles. PRIO_MODE = 1: all 4 port-0 writes granted before any port-1 write.
- Read latency sweep, READ_LAT = 0 and 3: read 0x20 holding 0xCAFEF00D -> rvalid at N and at N+3 respectively. With READ_LAT = 3, a port-1 request raised at N+1 gets its gnt at N+4.
- Reset mid-read, READ_LAT = 3: assert reset at N+1 -> no m0_rvalid at N+3; state returns to IDLE; a new read after release completes normally.
